pu_riscv_ahb_write_drain: RTL and testbench



---
 rtl/pu_riscv_ahb_drain_pkg.sv | 47 ++++
 rtl/pu_riscv_ahb_write_drain.sv | 183 ++++++++++++++++++
 tb/tb_pu_riscv_ahb_write_drain.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pu_riscv_ahb_drain_pkg.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb_drain_pkg
// Shared definitions for the write-buffer drain towards AHB3-Lite:
//   - AHB encodings for HTRANS, HBURST and HSIZE used by the drain
//   - layout of one packed queue entry {adr, size[2:0], data}
//   - helpers that return the bit offset of each entry field for a given XLEN
// ---------------------------------------------------------------------------
package pu_riscv_ahb_drain_pkg;

  // AHB transfer type encodings (only IDLE and NONSEQ are ever issued)
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // AHB burst encoding (single transfers only)
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // AHB transfer size encodings
  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;
  localparam logic [2:0] HSIZE_D = 3'b011;

  // Default entry geometry and field layout, LSB first: data, size, adr
  localparam int unsigned DRAIN_XLEN     = 64;
  localparam int unsigned DRAIN_PLEN     = 64;
  localparam int unsigned ENTRY_SIZE_W   = 3;
  localparam int unsigned ENTRY_DATA_LSB = 0;

  // One packed queue entry for the default geometry; the packing order
  // matches the queue output {adr, size, data}
  typedef struct packed {
    logic [DRAIN_PLEN-1:0]   adr;
    logic [ENTRY_SIZE_W-1:0] size;
    logic [DRAIN_XLEN-1:0]   data;
  } drain_entry_t;

  // Bit offset of the size field inside an entry
  function automatic int unsigned entry_size_lsb(input int unsigned xlen);
    return xlen;
  endfunction

  // Bit offset of the address field inside an entry
  function automatic int unsigned entry_adr_lsb(input int unsigned xlen);
    return xlen + ENTRY_SIZE_W;
  endfunction

endpackage

// File: rtl/pu_riscv_ahb_write_drain.sv
// ---------------------------------------------------------------------------
// pu_riscv_ahb_write_drain
// Pops packed store entries from the head of the write-buffer queue and
// issues each one as a single AHB3-Lite write, pipelined so that a new
// address phase can overlap the previous data phase. An ERROR response sets
// a sticky error (with the failing address) and stops issue until cleared.
//
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   clr_i              clears err_o / err_adr_o and re-enables issue
//   ena_i              allows popping new entries
//   q_empty_i, q_d_i   queue status and head entry {adr, size, data}
//   q_re_o             one-cycle pop strobe to the queue
//   HADDR..HWDATA      AHB3-Lite master outputs (writes only)
//   HREADY, HRESP      AHB3-Lite slave responses
//   busy_o             an address or data phase is outstanding
//   err_o, err_adr_o   sticky bus error and address of the failing write
// ---------------------------------------------------------------------------
module pu_riscv_ahb_write_drain
  import pu_riscv_ahb_drain_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PLEN       = 64,
  parameter logic [3:0]  HPROT_DATA = 4'b0011
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  ena_i,
  input  logic                  q_empty_i,
  input  logic [PLEN+3+XLEN-1:0] q_d_i,
  output logic                  q_re_o,
  output logic [PLEN-1:0]       HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  output logic [XLEN-1:0]       HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [PLEN-1:0]       err_adr_o
);

  localparam int unsigned SIZE_LSB = entry_size_lsb(XLEN);
  localparam int unsigned ADR_LSB  = entry_adr_lsb(XLEN);

  // Address-phase register: the entry currently presented on the bus
  logic            aph_valid_r, aph_valid_nxt_s;
  logic [PLEN-1:0] aph_adr_r,   aph_adr_nxt_s;
  logic [2:0]      aph_size_r,  aph_size_nxt_s;
  logic [XLEN-1:0] aph_data_r,  aph_data_nxt_s;
  logic [1:0]      htrans_r,    htrans_nxt_s;
  logic            hwrite_r,    hwrite_nxt_s;

  // Data-phase register: the write whose data is on HWDATA
  logic            dph_valid_r, dph_valid_nxt_s;
  logic [XLEN-1:0] hwdata_r,    hwdata_nxt_s;
  logic [PLEN-1:0] dph_adr_r,   dph_adr_nxt_s;

  // Sticky error
  logic            err_r,       err_nxt_s;
  logic [PLEN-1:0] err_adr_r,   err_adr_nxt_s;

  logic            abort_s;
  logic            load_s;

  // Next-state logic for both pipeline stages and the error capture
  always_comb begin
    // First cycle of the two-cycle ERROR response: the slave is still
    // holding HREADY low, and the master must drop any pending address.
    abort_s = dph_valid_r & HRESP & ~HREADY;
    // A new entry may enter the address phase when the previous address
    // is either absent or being accepted this cycle.
    load_s  = ena_i & ~q_empty_i & ~err_r & ~abort_s & (~aph_valid_r | HREADY);

    aph_valid_nxt_s = aph_valid_r;
    aph_adr_nxt_s   = aph_adr_r;
    aph_size_nxt_s  = aph_size_r;
    aph_data_nxt_s  = aph_data_r;
    htrans_nxt_s    = htrans_r;
    hwrite_nxt_s    = hwrite_r;
    dph_valid_nxt_s = dph_valid_r;
    hwdata_nxt_s    = hwdata_r;
    dph_adr_nxt_s   = dph_adr_r;
    err_nxt_s       = err_r;
    err_adr_nxt_s   = err_adr_r;

    // Address phase: a pending entry is dropped on abort (it was already
    // popped, so it is lost), otherwise replaced or retired on acceptance.
    if (abort_s) begin
      aph_valid_nxt_s = 1'b0;
      htrans_nxt_s    = HTRANS_IDLE;
      hwrite_nxt_s    = 1'b0;
    end else if (load_s) begin
      aph_valid_nxt_s = 1'b1;
      aph_adr_nxt_s   = q_d_i[ADR_LSB +: PLEN];
      aph_size_nxt_s  = q_d_i[SIZE_LSB +: 3];
      aph_data_nxt_s  = q_d_i[XLEN-1:0];
      htrans_nxt_s    = HTRANS_NONSEQ;
      hwrite_nxt_s    = 1'b1;
    end else if (aph_valid_r & HREADY) begin
      aph_valid_nxt_s = 1'b0;
      htrans_nxt_s    = HTRANS_IDLE;
      hwrite_nxt_s    = 1'b0;
    end else begin
      aph_valid_nxt_s = aph_valid_r;
    end

    // Data phase: an accepted address always moves into the data phase,
    // which also covers the back-to-back case; otherwise HREADY retires it.
    if (aph_valid_r & HREADY) begin
      dph_valid_nxt_s = 1'b1;
      hwdata_nxt_s    = aph_data_r;
      dph_adr_nxt_s   = aph_adr_r;
    end else if (dph_valid_r & HREADY) begin
      dph_valid_nxt_s = 1'b0;
    end else begin
      dph_valid_nxt_s = dph_valid_r;
    end

    // Error capture has priority over a simultaneous clear
    if (abort_s) begin
      err_nxt_s     = 1'b1;
      err_adr_nxt_s = dph_adr_r;
    end else if (clr_i) begin
      err_nxt_s     = 1'b0;
      err_adr_nxt_s = {PLEN{1'b0}};
    end else begin
      err_nxt_s     = err_r;
    end
  end

  // Pipeline and error state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aph_valid_r <= 1'b0;
      aph_adr_r   <= {PLEN{1'b0}};
      aph_size_r  <= 3'b000;
      aph_data_r  <= {XLEN{1'b0}};
      htrans_r    <= HTRANS_IDLE;
      hwrite_r    <= 1'b0;
      dph_valid_r <= 1'b0;
      hwdata_r    <= {XLEN{1'b0}};
      dph_adr_r   <= {PLEN{1'b0}};
      err_r       <= 1'b0;
      err_adr_r   <= {PLEN{1'b0}};
    end else begin
      aph_valid_r <= aph_valid_nxt_s;
      aph_adr_r   <= aph_adr_nxt_s;
      aph_size_r  <= aph_size_nxt_s;
      aph_data_r  <= aph_data_nxt_s;
      htrans_r    <= htrans_nxt_s;
      hwrite_r    <= hwrite_nxt_s;
      dph_valid_r <= dph_valid_nxt_s;
      hwdata_r    <= hwdata_nxt_s;
      dph_adr_r   <= dph_adr_nxt_s;
      err_r       <= err_nxt_s;
      err_adr_r   <= err_adr_nxt_s;
    end
  end

  // The pop strobe must coincide with the load so the entry reaches the
  // bus one cycle after the head becomes valid; it is masked during reset.
  assign q_re_o    = load_s & rst_ni;

  assign HADDR     = aph_adr_r;
  assign HSIZE     = aph_size_r;
  assign HTRANS    = htrans_r;
  assign HWRITE    = hwrite_r;
  assign HWDATA    = hwdata_r;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;

  assign busy_o    = aph_valid_r | dph_valid_r;
  assign err_o     = err_r;
  assign err_adr_o = err_adr_r;

endmodule

// File: tb/tb_pu_riscv_ahb_write_drain.sv
// ---------------------------------------------------------------------------
// tb_pu_riscv_ahb_write_drain
// Directed bench for the AHB write drain. The queue is modelled as a SV
// queue of entries; the expected bus view is kept as two transfer slots
// (address phase, data phase) that advance whenever HREADY is high.
// ---------------------------------------------------------------------------
module tb_pu_riscv_ahb_write_drain;
  import pu_riscv_ahb_drain_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned PLEN = 64;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   clr_i;
  logic                   ena_i;
  logic                   q_empty_i;
  logic [PLEN+3+XLEN-1:0] q_d_i;
  logic                   q_re_o;
  logic [PLEN-1:0]        HADDR;
  logic                   HWRITE;
  logic [2:0]             HSIZE;
  logic [2:0]             HBURST;
  logic [3:0]             HPROT;
  logic [1:0]             HTRANS;
  logic                   HMASTLOCK;
  logic [XLEN-1:0]        HWDATA;
  logic                   HREADY;
  logic                   HRESP;
  logic                   busy_o;
  logic                   err_o;
  logic [PLEN-1:0]        err_adr_o;

  pu_riscv_ahb_write_drain #(
    .XLEN       (XLEN),
    .PLEN       (PLEN),
    .HPROT_DATA (4'b0011)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .ena_i     (ena_i),
    .q_empty_i (q_empty_i),
    .q_d_i     (q_d_i),
    .q_re_o    (q_re_o),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HTRANS    (HTRANS),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .err_adr_o (err_adr_o)
  );

  always #5 clk_i = ~clk_i;

  // Queue contents seen by the DUT
  drain_entry_t fifo[$];

  // Transfer-level model of the bus
  bit           m_valid;
  bit           m_aph_v, m_dph_v, m_err;
  drain_entry_t m_aph, m_dph;
  logic [63:0]  m_err_adr;

  int checks, errors, pulses, cyc;
  logic [63:0] ns_adr[$];
  int          ns_cyc[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive_q();
    q_empty_i = (fifo.size() == 0);
    if (fifo.size() != 0) q_d_i = fifo[0];
    else                  q_d_i = '0;
  endtask

  task automatic push(input logic [63:0] adr, input logic [2:0] size, input logic [63:0] data);
    drain_entry_t e;
    e.adr = adr; e.size = size; e.data = data;
    fifo.push_back(e);
    drive_q();
  endtask

  // One clock: compare at the falling edge, then advance model and queue
  task automatic step();
    bit pop_exp, dut_pop, err_first, hr;
    drain_entry_t head;
    @(negedge clk_i);
    cyc++;
    if (fifo.size() != 0) head = fifo[0];
    else                  head = '0;
    hr        = HREADY;
    err_first = m_dph_v && HRESP && !HREADY;
    pop_exp   = rst_ni && ena_i && (fifo.size() != 0) && !m_err && !err_first
                && (!m_aph_v || HREADY);
    dut_pop   = q_re_o;
    if (m_valid) begin
      chk("q_re_o", q_re_o, pop_exp);
      chk("HTRANS", HTRANS, m_aph_v ? 2'b10 : 2'b00);
      chk("HWRITE", HWRITE, m_aph_v);
      if (m_aph_v) begin
        chk("HADDR", HADDR, m_aph.adr);
        chk("HSIZE", HSIZE, m_aph.size);
      end
      if (m_dph_v) chk("HWDATA", HWDATA, m_dph.data);
      chk("busy_o", busy_o, m_aph_v | m_dph_v);
      chk("err_o", err_o, m_err);
      chk("err_adr_o", err_adr_o, m_err_adr);
      chk("HBURST", HBURST, 3'b000);
      chk("HPROT", HPROT, 4'b0011);
      chk("HMASTLOCK", HMASTLOCK, 1'b0);
    end
    if (HTRANS == 2'b10) begin
      ns_adr.push_back(HADDR);
      ns_cyc.push_back(cyc);
    end
    if (dut_pop) pulses++;
    @(posedge clk_i);
    #1;
    if (!rst_ni) begin
      m_valid = 1'b1; m_aph_v = 1'b0; m_dph_v = 1'b0; m_err = 1'b0; m_err_adr = '0;
    end else begin
      if (err_first) begin
        m_err = 1'b1; m_err_adr = m_dph.adr;
      end else if (clr_i) begin
        m_err = 1'b0; m_err_adr = '0;
      end
      if (hr) begin
        m_dph_v = m_aph_v; m_dph = m_aph;
      end
      if (err_first)    m_aph_v = 1'b0;
      else if (pop_exp) begin m_aph_v = 1'b1; m_aph = head; end
      else if (hr)      m_aph_v = 1'b0;
    end
    if (dut_pop) void'(fifo.pop_front());
    drive_q();
  endtask

  initial begin
    int p0;
    checks = 0; errors = 0; pulses = 0; cyc = 0;
    m_valid = 1'b0; m_aph_v = 1'b0; m_dph_v = 1'b0; m_err = 1'b0; m_err_adr = '0;
    m_aph = '0; m_dph = '0;
    rst_ni = 1'b0; clr_i = 1'b0; ena_i = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
    drive_q();

    // Reset values
    step(); step();
    chk("rst_HTRANS", HTRANS, 2'b00);
    chk("rst_HADDR", HADDR, 64'h0);
    chk("rst_HSIZE", HSIZE, 3'b000);
    chk("rst_HWRITE", HWRITE, 1'b0);
    chk("rst_HWDATA", HWDATA, 64'h0);
    chk("rst_q_re_o", q_re_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_err_o", err_o, 1'b0);
    chk("rst_err_adr_o", err_adr_o, 64'h0);
    rst_ni = 1'b1;
    repeat (10) step();
    chk("idle_pulses", pulses, 0);

    // Single entry
    p0 = pulses;
    push(64'h1000, 3'd3, 64'hDEADBEEF_CAFEF00D);
    #1 chk("t1_pop", q_re_o, 1'b1);
    step();
    chk("t1_HTRANS", HTRANS, 2'b10);
    chk("t1_HADDR", HADDR, 64'h1000);
    chk("t1_HSIZE", HSIZE, 3'd3);
    chk("t1_HWRITE", HWRITE, 1'b1);
    step();
    chk("t1_HWDATA", HWDATA, 64'hDEADBEEF_CAFEF00D);
    chk("t1_idle", HTRANS, 2'b00);
    chk("t1_busy_dph", busy_o, 1'b1);
    step();
    chk("t1_busy_done", busy_o, 1'b0);
    chk("t1_pulses", pulses - p0, 1);

    // Four back-to-back entries (one with an out-of-range size)
    p0 = pulses;
    ns_adr.delete(); ns_cyc.delete();
    for (int i = 0; i < 4; i++)
      push(64'(i * 8), (i == 2) ? 3'b111 : 3'd3, 64'hA5A5_0000_0000_0000 + 64'(i));
    repeat (8) step();
    chk("t2_pulses", pulses - p0, 4);
    chk("t2_ns_count", ns_adr.size(), 4);
    if (ns_adr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_ns_adr", ns_adr[i], 64'(i * 8));
        chk("t2_ns_cyc", ns_cyc[i] - ns_cyc[0], i);
      end
    end

    // Wait states during the 0x20 address phase
    push(64'h20, 3'd3, 64'h2020_2020_2020_2020);
    push(64'h28, 3'd2, 64'h2828_2828_2828_2828);
    for (int k = 0; k < 10 && !(m_aph_v && m_aph.adr == 64'h20); k++) step();
    chk("t3_reach", m_aph_v && m_aph.adr == 64'h20, 1'b1);
    HREADY = 1'b0;
    p0 = pulses;
    repeat (3) begin
      #1;
      chk("t3_HADDR", HADDR, 64'h20);
      chk("t3_HTRANS", HTRANS, 2'b10);
      chk("t3_no_pop", q_re_o, 1'b0);
      step();
    end
    chk("t3_pulses", pulses - p0, 0);
    HREADY = 1'b1;
    #1 chk("t3_pop_resume", q_re_o, 1'b1);
    repeat (4) step();

    // ERROR on the 0x40 data phase, 0x48 pending behind it
    push(64'h40, 3'd3, 64'h4040_4040_4040_4040);
    push(64'h48, 3'd3, 64'h4848_4848_4848_4848);
    for (int k = 0; k < 10 && !(m_dph_v && m_dph.adr == 64'h40); k++) step();
    chk("t4_reach", m_dph_v && m_dph.adr == 64'h40, 1'b1);
    HRESP = 1'b1; HREADY = 1'b0;
    step();
    chk("t4_idle", HTRANS, 2'b00);
    chk("t4_err", err_o, 1'b1);
    chk("t4_err_adr", err_adr_o, 64'h40);
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    chk("t4_busy", busy_o, 1'b0);
    push(64'h50, 3'd3, 64'h5050_5050_5050_5050);
    p0 = pulses;
    repeat (3) step();
    chk("t4_no_pop", pulses - p0, 0);
    chk("t4_err_hold", err_o, 1'b1);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    #1;
    chk("t4_clr_err", err_o, 1'b0);
    chk("t4_clr_adr", err_adr_o, 64'h0);
    chk("t4_resume", q_re_o, 1'b1);
    repeat (4) step();

    // ena_i gating
    ena_i = 1'b0;
    push(64'h60, 3'd3, 64'h6060_6060_6060_6060);
    push(64'h68, 3'd3, 64'h6868_6868_6868_6868);
    p0 = pulses;
    repeat (4) step();
    chk("t5_no_pop", pulses - p0, 0);
    ena_i = 1'b1;
    #1 chk("t5_pop", q_re_o, 1'b1);
    step();
    chk("t5_HTRANS", HTRANS, 2'b10);
    chk("t5_HADDR", HADDR, 64'h60);
    repeat (6) step();
    chk("t5_drained", fifo.size(), 0);
    chk("t5_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
